// File: rtl/key_conditioner.sv
// key_conditioner: synchronizes, debounces and edge-detects active-low pushbuttons,
// producing a clean held level plus one-clock press, release and auto-repeat pulses per key.
module key_conditioner #(
    parameter int unsigned NUM_KEYS        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_RATE     = 5000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_repeat
);

    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RP_W   = $clog2(RP_MAX);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] RD_LAST = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0] RR_LAST = RP_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        StReleased,
        StHeldWait,
        StHeldRepeat
    } key_state_e;

    // Synchronizer flops carry the raw active-low level, so reset value 1 means released.
    logic [NUM_KEYS-1:0] sync1_q, sync2_q;
    logic [NUM_KEYS-1:0] pressed;

    // Two-flop synchronizer for the asynchronous buttons.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
        end
    end

    assign pressed = ~sync2_q;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        logic [DB_W-1:0] db_cnt_q, db_cnt_d;
        logic [RP_W-1:0] rp_cnt_q, rp_cnt_d;
        logic            level_q, level_d;
        logic            accept;
        key_state_e      state_q, state_d;
        logic            press_q, press_d;
        logic            release_q, release_d;
        logic            repeat_q, repeat_d;

        // Per-key state and registered output pulses.
        always_ff @(posedge clk) begin
            if (rst) begin
                db_cnt_q  <= '0;
                rp_cnt_q  <= '0;
                level_q   <= 1'b0;
                state_q   <= StReleased;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                repeat_q  <= 1'b0;
            end else begin
                db_cnt_q  <= db_cnt_d;
                rp_cnt_q  <= rp_cnt_d;
                level_q   <= level_d;
                state_q   <= state_d;
                press_q   <= press_d;
                release_q <= release_d;
                repeat_q  <= repeat_d;
            end
        end

        // Debounce counter and key FSM next-state; a release always beats a due repeat.
        always_comb begin
            db_cnt_d  = db_cnt_q;
            level_d   = level_q;
            accept    = 1'b0;
            state_d   = state_q;
            rp_cnt_d  = rp_cnt_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            repeat_d  = 1'b0;

            if (pressed[i] == level_q) begin
                db_cnt_d = '0;
            end else if (db_cnt_q == DB_LAST) begin
                level_d  = pressed[i];
                db_cnt_d = '0;
                accept   = 1'b1;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end

            unique case (state_q)
                StReleased: begin
                    if (accept && pressed[i]) begin
                        press_d  = 1'b1;
                        rp_cnt_d = '0;
                        state_d  = StHeldWait;
                    end
                end
                StHeldWait: begin
                    if (accept && !pressed[i]) begin
                        release_d = 1'b1;
                        rp_cnt_d  = '0;
                        state_d   = StReleased;
                    end else if (rp_cnt_q == RD_LAST) begin
                        repeat_d = 1'b1;
                        rp_cnt_d = '0;
                        state_d  = StHeldRepeat;
                    end else begin
                        rp_cnt_d = rp_cnt_q + 1'b1;
                    end
                end
                StHeldRepeat: begin
                    if (accept && !pressed[i]) begin
                        release_d = 1'b1;
                        rp_cnt_d  = '0;
                        state_d   = StReleased;
                    end else if (rp_cnt_q == RR_LAST) begin
                        repeat_d = 1'b1;
                        rp_cnt_d = '0;
                    end else begin
                        rp_cnt_d = rp_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d  = StReleased;
                    rp_cnt_d = '0;
                end
            endcase
        end

        assign key_level[i]   = level_q;
        assign key_press[i]   = press_q;
        assign key_release[i] = release_q;
        assign key_repeat[i]  = repeat_q;
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed self-checking bench for key_conditioner with short debounce/repeat timings.
module tb_key_conditioner;

    localparam int NK = 4;

    logic          clk;
    logic          rst;
    logic [NK-1:0] key_n;
    logic [NK-1:0] key_level, key_press, key_release, key_repeat;

    int pass_cnt  = 0;
    int total_cnt = 0;

    key_conditioner #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_RATE     (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_n       (key_n),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_repeat  (key_repeat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        logic [15:0] obs;
        rst   = 1'b1;
        key_n = '1;
        idle(2);
        obs = {key_level, key_press, key_release, key_repeat};
        total_cnt++;
        if (obs !== 16'h0000) $display("FAIL reset: got %h expected %h", obs, 16'h0000);
        else pass_cnt++;
        rst = 1'b0;
        idle(3);
        obs = {key_level, key_press, key_release, key_repeat};
        total_cnt++;
        if (obs !== 16'h0000) $display("FAIL reset_idle: got %h expected %h", obs, 16'h0000);
        else pass_cnt++;
    endtask

    // Key 3 press then release; each accepted 6 clocks after the first sampling edge.
    task automatic test_clean_press();
        logic [15:0] obs, exp;
        key_n[3] = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            tick();
            exp = {4'((c >= 6) ? 8 : 0), 4'((c == 6) ? 8 : 0), 4'h0, 4'h0};
            obs = {key_level, key_press, key_release, key_repeat};
            total_cnt++;
            if (obs !== exp) $display("FAIL clean_press c=%0d: got %h expected %h", c, obs, exp);
            else pass_cnt++;
        end
        key_n[3] = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            exp = {4'((c < 6) ? 8 : 0), 4'h0, 4'((c == 6) ? 8 : 0), 4'h0};
            obs = {key_level, key_press, key_release, key_repeat};
            total_cnt++;
            if (obs !== exp) $display("FAIL clean_release c=%0d: got %h expected %h", c, obs, exp);
            else pass_cnt++;
        end
    endtask

    // Key 0 toggles every 2 clocks; never stable long enough to be accepted.
    task automatic test_bounce();
        logic [15:0] obs;
        for (int c = 0; c < 30; c++) begin
            key_n[0] = (c < 20) ? c[1] : 1'b1;
            tick();
            obs = {key_level, key_press, key_release, key_repeat};
            total_cnt++;
            if (obs !== 16'h0000) $display("FAIL bounce c=%0d: got %h expected %h", c, obs, 16'h0000);
            else pass_cnt++;
        end
    endtask

    // Key 1 held: repeats at +10 then every 3; repeats continue during release debounce.
    task automatic test_auto_repeat();
        logic [15:0] obs, exp;
        logic        rp;
        key_n[1] = 1'b0;
        idle(5);
        tick();
        obs = {key_level, key_press, key_release, key_repeat};
        total_cnt++;
        if (obs !== 16'h2200) $display("FAIL repeat_press: got %h expected %h", obs, 16'h2200);
        else pass_cnt++;
        for (int k = 1; k <= 37; k++) begin
            if (k == 31) key_n[1] = 1'b1;
            tick();
            rp  = (k >= 10) && (k < 36) && ((k - 10) % 3 == 0);
            exp = {4'((k < 36) ? 2 : 0), 4'h0, 4'((k == 36) ? 2 : 0), 4'(rp ? 2 : 0)};
            obs = {key_level, key_press, key_release, key_repeat};
            total_cnt++;
            if (obs !== exp) $display("FAIL auto_repeat k=%0d: got %h expected %h", k, obs, exp);
            else pass_cnt++;
        end
    endtask

    // Key 2 release accepted on the exact cycle a repeat would fire (offset from press).
    task automatic test_release_collision(input int off);
        logic [15:0] obs, exp;
        logic        rp;
        key_n[2] = 1'b0;
        idle(5);
        tick();
        obs = {key_level, key_press, key_release, key_repeat};
        total_cnt++;
        if (obs !== 16'h4400) $display("FAIL collision_press off=%0d: got %h expected %h", off, obs, 16'h4400);
        else pass_cnt++;
        for (int k = 1; k <= 30; k++) begin
            if (k == off - 5) key_n[2] = 1'b1;
            tick();
            rp  = (k >= 10) && (k < off) && ((k - 10) % 3 == 0);
            exp = {4'((k < off) ? 4 : 0), 4'h0, 4'((k == off) ? 4 : 0), 4'(rp ? 4 : 0)};
            obs = {key_level, key_press, key_release, key_repeat};
            total_cnt++;
            if (obs !== exp) $display("FAIL collision off=%0d k=%0d: got %h expected %h", off, k, obs, exp);
            else pass_cnt++;
        end
    endtask

    // Keys 0 and 2 pressed and released together; events coincide.
    task automatic test_simultaneous();
        logic [15:0] obs, exp;
        key_n = 4'b1010;
        for (int c = 1; c <= 7; c++) begin
            tick();
            exp = {4'((c >= 6) ? 5 : 0), 4'((c == 6) ? 5 : 0), 4'h0, 4'h0};
            obs = {key_level, key_press, key_release, key_repeat};
            total_cnt++;
            if (obs !== exp) $display("FAIL simul_press c=%0d: got %h expected %h", c, obs, exp);
            else pass_cnt++;
        end
        key_n = 4'b1111;
        for (int c = 1; c <= 7; c++) begin
            tick();
            exp = {4'((c < 6) ? 5 : 0), 4'h0, 4'((c == 6) ? 5 : 0), 4'h0};
            obs = {key_level, key_press, key_release, key_repeat};
            total_cnt++;
            if (obs !== exp) $display("FAIL simul_release c=%0d: got %h expected %h", c, obs, exp);
            else pass_cnt++;
        end
    endtask

    // Reset while key 3 is in auto-repeat; no release, fresh press after full latency.
    task automatic test_reset_mid_hold();
        logic [15:0] obs, exp;
        key_n[3] = 1'b0;
        idle(6);
        idle(12);
        obs = {key_level, key_press, key_release, key_repeat};
        total_cnt++;
        if (obs !== 16'h8000) $display("FAIL pre_reset_hold: got %h expected %h", obs, 16'h8000);
        else pass_cnt++;
        rst = 1'b1;
        tick();
        obs = {key_level, key_press, key_release, key_repeat};
        total_cnt++;
        if (obs !== 16'h0000) $display("FAIL mid_reset: got %h expected %h", obs, 16'h0000);
        else pass_cnt++;
        rst = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            tick();
            exp = {4'((c >= 6) ? 8 : 0), 4'((c == 6) ? 8 : 0), 4'h0, 4'h0};
            obs = {key_level, key_press, key_release, key_repeat};
            total_cnt++;
            if (obs !== exp) $display("FAIL reset_repress c=%0d: got %h expected %h", c, obs, exp);
            else pass_cnt++;
        end
        key_n[3] = 1'b1;
        idle(10);
        obs = {key_level, key_press, key_release, key_repeat};
        total_cnt++;
        if (obs !== 16'h0000) $display("FAIL reset_final: got %h expected %h", obs, 16'h0000);
        else pass_cnt++;
    endtask

    initial begin
        rst   = 1'b1;
        key_n = '1;
        test_reset();
        test_clean_press();
        idle(4);
        test_bounce();
        idle(4);
        test_auto_repeat();
        idle(4);
        test_release_collision(13);
        idle(4);
        test_release_collision(10);
        idle(4);
        test_simultaneous();
        idle(4);
        test_reset_mid_hold();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
